// File: rtl/mavg_level_detector.sv
// Hysteresis level detector with consecutive-sample debounce and per-episode peak/length reporting.
// Optional sticky saturation flag (clr_sat_i / sat_o) enabled by defining MAVG_LEVEL_DET_SAT_FLAG_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOW       | level low, waiting for a sample above thr_hi_i
// RISE_PEND | counting consecutive above samples toward a confirmed rise
// HIGH      | level high, tracking peak and episode length
// FALL_PEND | counting consecutive below samples toward a confirmed fall
module mavg_level_detector #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic signed [7:0]       avg_i,
    input  logic                    avg_valid_i,
    input  logic signed [7:0]       thr_hi_i,
    input  logic signed [7:0]       thr_lo_i,
`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
    input  logic                    clr_sat_i,
    output logic                    sat_o,
`endif
    output logic                    level_o,
    output logic                    rise_o,
    output logic                    fall_o,
    output logic signed [7:0]       peak_o,
    output logic [LEN_W-1:0]        episode_len_o,
    output logic                    peak_valid_o
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } state_t;

    localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic signed [7:0] PEAK_RST = 8'sh80;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic signed [7:0]     peak_q, peak_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  rise_d, fall_d;

    logic                  level_q, rise_q, fall_q, pvalid_q;
    logic signed [7:0]     peak_out_q;
    logic [LEN_W-1:0]      len_out_q;

    logic                  above, below;
    logic signed [7:0]     peak_max;
    logic [LEN_W-1:0]      len_inc;
    logic [3:0]            cnt_inc;

    assign above    = avg_i > thr_hi_i;
    assign below    = avg_i < thr_lo_i;
    assign peak_max = (avg_i > peak_q) ? avg_i : peak_q;
    assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
    assign cnt_inc  = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        len_d   = len_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (avg_valid_i) begin
            unique case (state_q)
                LOW: begin
                    if (above) begin
                        peak_d = avg_i;
                        if (DEB == 4'd1) begin
                            state_d = HIGH;
                            rise_d  = 1'b1;
                            len_d   = '0;
                        end else begin
                            state_d = RISE_PEND;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                RISE_PEND: begin
                    if (above) begin
                        peak_d = peak_max;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == DEB) begin
                            state_d = HIGH;
                            cnt_d   = 4'd0;
                            rise_d  = 1'b1;
                            len_d   = '0;
                        end
                    end else begin
                        state_d = LOW;
                        cnt_d   = 4'd0;
                    end
                end
                HIGH: begin
                    peak_d = peak_max;
                    len_d  = len_inc;
                    if (below) begin
                        if (DEB == 4'd1) begin
                            state_d = LOW;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = FALL_PEND;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                FALL_PEND: begin
                    peak_d = peak_max;
                    len_d  = len_inc;
                    if (below) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB) begin
                            state_d = LOW;
                            cnt_d   = 4'd0;
                            fall_d  = 1'b1;
                        end
                    end else begin
                        state_d = HIGH;
                        cnt_d   = 4'd0;
                    end
                end
                default: state_d = LOW;
            endcase
        end
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q    <= LOW;
            cnt_q      <= 4'd0;
            peak_q     <= PEAK_RST;
            len_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            pvalid_q   <= 1'b0;
            peak_out_q <= 8'sd0;
            len_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            len_q    <= len_d;
            level_q  <= (state_d == HIGH) || (state_d == FALL_PEND);
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pvalid_q <= fall_d;
            // The reported peak/length include the confirming fall sample.
            if (fall_d) begin
                peak_out_q <= peak_d;
                len_out_q  <= len_d;
            end
        end
    end

    assign level_o       = level_q;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign peak_valid_o  = pvalid_q;
    assign peak_o        = peak_out_q;
    assign episode_len_o = len_out_q;

`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
    logic sat_q;
    logic sat_hit;

    assign sat_hit = avg_valid_i && ((avg_i == 8'sh80) || (avg_i == 8'sh7F));

    // Set has priority over clear so a saturating sample is never lost.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            sat_q <= 1'b0;
        end else if (sat_hit) begin
            sat_q <= 1'b1;
        end else if (clr_sat_i) begin
            sat_q <= 1'b0;
        end
    end

    assign sat_o = sat_q;
`endif

endmodule

// File: tb/tb_mavg_level_detector.sv
// Directed test of mavg_level_detector with DEBOUNCE=1 and DEBOUNCE=3 instances on shared inputs.
// The saturation-flag scenario runs only when MAVG_LEVEL_DET_SAT_FLAG_EN is defined.
module tb_mavg_level_detector;

    logic              clk;
    logic              rstn;
    logic signed [7:0] avg;
    logic              vld;
    logic signed [7:0] thr_hi;
    logic signed [7:0] thr_lo;

    logic              lvl1, rise1, fall1, pv1;
    logic signed [7:0] peak1;
    logic [15:0]       len1;
    logic              lvl3, rise3, fall3, pv3;
    logic signed [7:0] peak3;
    logic [15:0]       len3;
`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
    logic              clr_sat;
    logic              sat1, sat3;
`endif

    int errors = 0;
    int checks = 0;

    mavg_level_detector #(.DEBOUNCE(1), .LEN_W(16)) u_db1 (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .avg_i           (avg),
        .avg_valid_i     (vld),
        .thr_hi_i        (thr_hi),
        .thr_lo_i        (thr_lo),
`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
        .clr_sat_i       (clr_sat),
        .sat_o           (sat1),
`endif
        .level_o         (lvl1),
        .rise_o          (rise1),
        .fall_o          (fall1),
        .peak_o          (peak1),
        .episode_len_o   (len1),
        .peak_valid_o    (pv1)
    );

    mavg_level_detector #(.DEBOUNCE(3), .LEN_W(16)) u_db3 (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .avg_i           (avg),
        .avg_valid_i     (vld),
        .thr_hi_i        (thr_hi),
        .thr_lo_i        (thr_lo),
`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
        .clr_sat_i       (clr_sat),
        .sat_o           (sat3),
`endif
        .level_o         (lvl3),
        .rise_o          (rise3),
        .fall_o          (fall3),
        .peak_o          (peak3),
        .episode_len_o   (len3),
        .peak_valid_o    (pv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input at the falling edge; outputs are sampled 1 ns after the next rising edge.
    task automatic send(input logic signed [7:0] v, input logic valid);
        @(negedge clk);
        avg = v;
        vld = valid;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        vld  = 1'b0;
        send(8'sd0, 1'b0);
        send(8'sd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (lvl3 !== 1'b0)  begin errors++; $display("FAIL reset_level got=%b exp=0", lvl3); end
        checks++; if ({rise3, fall3, pv3, rise1, fall1, pv1} !== 6'b0)
            begin errors++; $display("FAIL reset_pulses got=%b exp=000000", {rise3, fall3, pv3, rise1, fall1, pv1}); end
        checks++; if (peak3 !== 8'sd0) begin errors++; $display("FAIL reset_peak got=%0d exp=0", peak3); end
        checks++; if (len3 !== 16'd0)  begin errors++; $display("FAIL reset_len got=%0d exp=0", len3); end
    endtask

    task automatic test_rise_nodeb();
        do_reset();
        send(8'sd20, 1'b1);
        checks++; if ({rise1, lvl1} !== 2'b00) begin errors++; $display("FAIL db1_equal_thr got=%b exp=00", {rise1, lvl1}); end
        send(8'sd21, 1'b1);
        checks++; if ({rise1, lvl1} !== 2'b11) begin errors++; $display("FAIL db1_rise got=%b exp=11", {rise1, lvl1}); end
        checks++; if ({rise3, lvl3} !== 2'b00) begin errors++; $display("FAIL db3_no_early_rise got=%b exp=00", {rise3, lvl3}); end
        send(8'sd0, 1'b0);
        checks++; if ({rise1, lvl1} !== 2'b01) begin errors++; $display("FAIL db1_rise_one_cycle got=%b exp=01", {rise1, lvl1}); end
    endtask

    task automatic test_aborted_rise();
        logic signed [7:0] seq [3];
        do_reset();
        seq = '{8'sd25, 8'sd30, 8'sd15};
        for (int i = 0; i < 3; i++) begin
            send(seq[i], 1'b1);
            checks++; if ({rise3, lvl3} !== 2'b00)
                begin errors++; $display("FAIL abort_rise[%0d] got=%b exp=00", i, {rise3, lvl3}); end
        end
        send(8'sd25, 1'b1);
        send(8'sd30, 1'b1);
        checks++; if (rise3 !== 1'b0) begin errors++; $display("FAIL rise_before_third got=%b exp=0", rise3); end
        send(8'sd28, 1'b1);
        checks++; if ({rise3, lvl3} !== 2'b11) begin errors++; $display("FAIL rise_after_28 got=%b exp=11", {rise3, lvl3}); end
        send(8'sd0, 1'b0);
        checks++; if (rise3 !== 1'b0) begin errors++; $display("FAIL rise_pulse_width got=%b exp=0", rise3); end
    endtask

    // gap inserts an idle cycle after every valid sample; results must match the gap-free run.
    task automatic run_full_episode(input logic gap, input string tag);
        logic signed [7:0] seq [7];
        logic [6:0]        exp_rise, exp_fall, exp_lvl;
        do_reset();
        seq      = '{8'sd25, 8'sd40, 8'sd33, 8'sd12, 8'sd5, 8'sd4, 8'sd3};
        exp_rise = 7'b0000100;
        exp_fall = 7'b1000000;
        exp_lvl  = 7'b0111100;
        for (int i = 0; i < 7; i++) begin
            send(seq[i], 1'b1);
            checks++; if ({rise3, fall3, pv3, lvl3} !== {exp_rise[i], exp_fall[i], exp_fall[i], exp_lvl[i]})
                begin errors++; $display("FAIL %s_step[%0d] rise/fall/pv/lvl got=%b exp=%b", tag, i,
                      {rise3, fall3, pv3, lvl3}, {exp_rise[i], exp_fall[i], exp_fall[i], exp_lvl[i]}); end
            if (i == 4) begin
                checks++; if ({fall1, pv1, peak1, len1} !== {1'b1, 1'b1, 8'sd40, 16'd4})
                    begin errors++; $display("FAIL %s_db1_fall got fall=%b pv=%b peak=%0d len=%0d exp 1 1 40 4",
                          tag, fall1, pv1, peak1, len1); end
            end
            if (gap) begin
                send(8'sd100, 1'b0);
                checks++; if ({rise3, fall3, pv3, lvl3} !== {3'b000, exp_lvl[i]})
                    begin errors++; $display("FAIL %s_gap[%0d] got=%b exp=%b", tag, i,
                          {rise3, fall3, pv3, lvl3}, {3'b000, exp_lvl[i]}); end
            end
        end
        checks++; if (peak3 !== 8'sd40) begin errors++; $display("FAIL %s_peak got=%0d exp=40", tag, peak3); end
        checks++; if (len3 !== 16'd4)   begin errors++; $display("FAIL %s_len got=%0d exp=4", tag, len3); end
    endtask

    task automatic test_full_episode();
        run_full_episode(1'b0, "episode");
        send(8'sd0, 1'b0);
        checks++; if ({fall3, pv3, peak3} !== {2'b00, 8'sd40})
            begin errors++; $display("FAIL episode_hold got fall=%b pv=%b peak=%0d exp 0 0 40", fall3, pv3, peak3); end
    endtask

    task automatic test_gaps();
        run_full_episode(1'b1, "gaps");
    endtask

    task automatic test_glitch_fall();
        logic signed [7:0] seq [6];
        do_reset();
        send(8'sd25, 1'b1);
        send(8'sd30, 1'b1);
        send(8'sd28, 1'b1);
        send(8'sd10, 1'b1);
        checks++; if ({lvl3, fall3} !== 2'b10) begin errors++; $display("FAIL equal_lo_no_fall got=%b exp=10", {lvl3, fall3}); end
        seq = '{8'sd5, 8'sd5, 8'sd15, 8'sd5, 8'sd5, 8'sd5};
        for (int i = 0; i < 6; i++) begin
            send(seq[i], 1'b1);
            checks++; if (fall3 !== (i == 5))
                begin errors++; $display("FAIL glitch_fall[%0d] got=%b exp=%b", i, fall3, (i == 5)); end
        end
        checks++; if ({peak3, len3} !== {8'sd30, 16'd7})
            begin errors++; $display("FAIL glitch_result got peak=%0d len=%0d exp 30 7", peak3, len3); end
        // Same scenario without the extra equal-threshold sample gives length 6.
        do_reset();
        send(8'sd25, 1'b1);
        send(8'sd30, 1'b1);
        send(8'sd28, 1'b1);
        for (int i = 0; i < 6; i++) send(seq[i], 1'b1);
        checks++; if ({fall3, len3} !== {1'b1, 16'd6})
            begin errors++; $display("FAIL glitch_len6 got fall=%b len=%0d exp 1 6", fall3, len3); end
    endtask

    task automatic test_reset_mid_episode();
        do_reset();
        send(8'sd25, 1'b1);
        send(8'sd30, 1'b1);
        send(8'sd28, 1'b1);
        send(8'sd5, 1'b1);
        send(8'sd5, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        send(8'sd5, 1'b1);
        checks++; if ({lvl3, rise3, fall3, pv3, peak3, len3} !== {4'b0000, 8'sd0, 16'd0})
            begin errors++; $display("FAIL midreset_outputs got lvl=%b r=%b f=%b pv=%b peak=%0d len=%0d exp all 0",
                  lvl3, rise3, fall3, pv3, peak3, len3); end
        @(negedge clk);
        rstn = 1'b1;
        send(8'sd5, 1'b1);
        send(8'sd0, 1'b0);
        checks++; if ({lvl3, fall3, pv3} !== 3'b000)
            begin errors++; $display("FAIL midreset_no_fall got=%b exp=000", {lvl3, fall3, pv3}); end
    endtask

`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
    task automatic test_sat_flag();
        do_reset();
        checks++; if (sat3 !== 1'b0) begin errors++; $display("FAIL sat_reset got=%b exp=0", sat3); end
        send(8'sd127, 1'b1);
        checks++; if (sat3 !== 1'b1) begin errors++; $display("FAIL sat_set got=%b exp=1", sat3); end
        send(8'sd0, 1'b1);
        checks++; if (sat3 !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", sat3); end
        @(negedge clk);
        clr_sat = 1'b1;
        send(8'sd0, 1'b0);
        clr_sat = 1'b0;
        checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL sat_clear got=%b exp=0", sat1); end
        send(8'sd127, 1'b0);
        checks++; if (sat3 !== 1'b0) begin errors++; $display("FAIL sat_invalid_ignored got=%b exp=0", sat3); end
        @(negedge clk);
        clr_sat = 1'b1;
        send(-8'sd128, 1'b1);
        clr_sat = 1'b0;
        checks++; if (sat3 !== 1'b1) begin errors++; $display("FAIL sat_set_wins got=%b exp=1", sat3); end
    endtask
`endif

    initial begin
        rstn   = 1'b0;
        avg    = 8'sd0;
        vld    = 1'b0;
        thr_hi = 8'sd20;
        thr_lo = 8'sd10;
`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
        clr_sat = 1'b0;
`endif
        test_reset();
        test_rise_nodeb();
        test_aborted_rise();
        test_full_episode();
        test_gaps();
        test_glitch_fall();
        test_reset_mid_episode();
`ifdef MAVG_LEVEL_DET_SAT_FLAG_EN
        test_sat_flag();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
